// File: rtl/dpram_reg_master.sv
// dpram_reg_master: sequencer owning the holding-register port of the Modbus
// register DPRAM. Bounds-checks read/write-register requests, then moves the
// words one at a time between the RAM port and the read/write streams.
// Optional feature: define REG_READBACK_EN to read back and verify every
// committed word (mismatch aborts the request with exception 0x04).
module dpram_reg_master #(
  parameter int unsigned A_WIDTH = 4,
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned MAX_QTY = 8
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic               REQ_WR,
  input  logic [15:0]        REQ_ADDR,
  input  logic [7:0]         REQ_QTY,
  input  logic [D_WIDTH-1:0] WR_DATA,
  input  logic               WR_VALID,
  output logic               WR_READY,
  output logic [D_WIDTH-1:0] RD_DATA,
  output logic               RD_VALID,
  input  logic               RD_READY,
  output logic               DONE,
  output logic [7:0]         EXC,
  output logic               RAM_EN,
  output logic               RAM_WE,
  output logic [A_WIDTH-1:0] RAM_ADDR,
  output logic [D_WIDTH-1:0] RAM_DI,
  input  logic [D_WIDTH-1:0] RAM_DO
);

  localparam int unsigned SUM_W     = 17;
  localparam int unsigned MAP_WORDS = 1 << A_WIDTH;
  localparam logic [7:0]  EXC_OK    = 8'h00;
  localparam logic [7:0]  EXC_ADDR  = 8'h02;
  localparam logic [7:0]  EXC_QTY   = 8'h03;
`ifdef REG_READBACK_EN
  localparam logic [7:0]  EXC_VERIFY = 8'h04;
`endif

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    RD_ISSUE,
    RD_CAPT,
    RD_OUT,
    WR_ACCEPT,
    WR_COMMIT,
`ifdef REG_READBACK_EN
    WR_VERIFY,
`endif
    FINISH
  } state_t;

  state_t               state_q, state_n;
  logic                 wr_q, wr_n;
  logic [15:0]          addr_q, addr_n;
  logic [7:0]           qty_q, qty_n;
  logic [7:0]           idx_q, idx_n;
  logic [7:0]           exc_q, exc_n;
  logic                 done_q, done_n;
  logic [D_WIDTH-1:0]   rd_data_q, rd_data_n;
  logic                 rd_valid_q, rd_valid_n;
  logic                 ram_en_q, ram_en_n;
  logic                 ram_we_q, ram_we_n;
  logic [A_WIDTH-1:0]   ram_addr_q, ram_addr_n;
  logic [D_WIDTH-1:0]   ram_di_q, ram_di_n;

  logic [SUM_W-1:0]     addr_end;
  logic [A_WIDTH-1:0]   base;
  logic [7:0]           idx_inc;

  // End address of the request, wide enough that 0xFFFF + qty cannot wrap
  assign addr_end = SUM_W'(addr_q) + SUM_W'(qty_q);
  assign base     = addr_q[A_WIDTH-1:0];
  assign idx_inc  = idx_q + 8'd1;

  // Ready signals decode from state; REQ_READY is held low while in reset
  assign REQ_READY = (state_q == IDLE) && !RESET;
  assign WR_READY  = (state_q == WR_ACCEPT);

  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;
  assign DONE     = done_q;
  assign EXC      = exc_q;
  assign RAM_EN   = ram_en_q;
  assign RAM_WE   = ram_we_q;
  assign RAM_ADDR = ram_addr_q;
  assign RAM_DI   = ram_di_q;

  // Next-state and next-output decode
  always_comb begin
    state_n    = state_q;
    wr_n       = wr_q;
    addr_n     = addr_q;
    qty_n      = qty_q;
    idx_n      = idx_q;
    exc_n      = exc_q;
    rd_data_n  = rd_data_q;
    rd_valid_n = rd_valid_q;
    ram_en_n   = 1'b0;
    ram_we_n   = 1'b0;
    ram_addr_n = ram_addr_q;
    ram_di_n   = ram_di_q;

    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          wr_n    = REQ_WR;
          addr_n  = REQ_ADDR;
          qty_n   = REQ_QTY;
          idx_n   = 8'd0;
          exc_n   = EXC_OK;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if ((qty_q == 8'd0) || (32'(qty_q) > MAX_QTY)) begin
          exc_n   = EXC_QTY;
          state_n = FINISH;
        end else if (addr_end > SUM_W'(MAP_WORDS)) begin
          exc_n   = EXC_ADDR;
          state_n = FINISH;
        end else if (wr_q) begin
          state_n = WR_ACCEPT;
        end else begin
          ram_en_n   = 1'b1;
          ram_addr_n = base + A_WIDTH'(idx_q);
          state_n    = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        state_n = RD_CAPT;
      end
      RD_CAPT: begin
        rd_data_n  = RAM_DO;
        rd_valid_n = 1'b1;
        state_n    = RD_OUT;
      end
      RD_OUT: begin
        if (RD_READY) begin
          rd_valid_n = 1'b0;
          idx_n      = idx_inc;
          if (idx_inc == qty_q) begin
            state_n = FINISH;
          end else begin
            ram_en_n   = 1'b1;
            ram_addr_n = base + A_WIDTH'(idx_inc);
            state_n    = RD_ISSUE;
          end
        end
      end
      WR_ACCEPT: begin
        if (WR_VALID) begin
          ram_en_n   = 1'b1;
          ram_we_n   = 1'b1;
          ram_di_n   = WR_DATA;
          ram_addr_n = base + A_WIDTH'(idx_q);
          state_n    = WR_COMMIT;
        end
      end
      WR_COMMIT: begin
        idx_n = idx_inc;
`ifdef REG_READBACK_EN
        state_n = WR_VERIFY;
`else
        state_n = (idx_inc == qty_q) ? FINISH : WR_ACCEPT;
`endif
      end
`ifdef REG_READBACK_EN
      WR_VERIFY: begin
        if (RAM_DO != ram_di_q) begin
          exc_n   = EXC_VERIFY;
          state_n = FINISH;
        end else begin
          state_n = (idx_q == qty_q) ? FINISH : WR_ACCEPT;
        end
      end
`endif
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    done_n = (state_n == FINISH);
  end

  // State and registered outputs; synchronous reset abandons any transfer
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      qty_q      <= '0;
      idx_q      <= '0;
      exc_q      <= EXC_OK;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_di_q   <= '0;
    end else begin
      state_q    <= state_n;
      wr_q       <= wr_n;
      addr_q     <= addr_n;
      qty_q      <= qty_n;
      idx_q      <= idx_n;
      exc_q      <= exc_n;
      done_q     <= done_n;
      rd_data_q  <= rd_data_n;
      rd_valid_q <= rd_valid_n;
      ram_en_q   <= ram_en_n;
      ram_we_q   <= ram_we_n;
      ram_addr_q <= ram_addr_n;
      ram_di_q   <= ram_di_n;
    end
  end

endmodule

// File: tb/tb_dpram_reg_master.sv
// Testbench for dpram_reg_master: behavioural RAM, reference register map,
// directed scenarios plus randomized requests.
module tb_dpram_reg_master;

  localparam int unsigned A_WIDTH = 4;
  localparam int unsigned D_WIDTH = 16;
  localparam int unsigned MAX_QTY = 8;
  localparam int unsigned WORDS   = 1 << A_WIDTH;
`ifdef REG_READBACK_EN
  localparam int WR_TAIL = 3;
`else
  localparam int WR_TAIL = 2;
`endif

  logic               CLOCK = 1'b0;
  logic               RESET = 1'b1;
  logic               REQ_VALID = 1'b0;
  logic               REQ_READY;
  logic               REQ_WR = 1'b0;
  logic [15:0]        REQ_ADDR = '0;
  logic [7:0]         REQ_QTY = '0;
  logic [D_WIDTH-1:0] WR_DATA = '0;
  logic               WR_VALID = 1'b0;
  logic               WR_READY;
  logic [D_WIDTH-1:0] RD_DATA;
  logic               RD_VALID;
  logic               RD_READY = 1'b1;
  logic               DONE;
  logic [7:0]         EXC;
  logic               RAM_EN;
  logic               RAM_WE;
  logic [A_WIDTH-1:0] RAM_ADDR;
  logic [D_WIDTH-1:0] RAM_DI;
  logic [D_WIDTH-1:0] RAM_DO;

  dpram_reg_master #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .MAX_QTY(MAX_QTY)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_QTY(REQ_QTY),
    .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
    .DONE(DONE), .EXC(EXC),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
    .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  always #5 CLOCK = ~CLOCK;

  // Behavioural RAM port (write-first), with preload path and operation logs
  logic [15:0] mem [0:WORDS-1];
  logic [15:0] ram_do_r = '0;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  int          en_cnt = 0;
  int          we_cnt = 0;
  int          rd_cnt = 0;
  int          corrupt_at = -1;
  logic [3:0]  waddr_log [0:1023];
  logic [3:0]  raddr_log [0:1023];

  assign RAM_DO = ram_do_r;

  always @(posedge CLOCK) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (RAM_EN) begin
      en_cnt <= en_cnt + 1;
      if (RAM_WE) begin
        mem[RAM_ADDR] <= RAM_DI;
        waddr_log[we_cnt & 1023] <= RAM_ADDR;
        ram_do_r <= (we_cnt == corrupt_at) ? ~RAM_DI : RAM_DI;
        we_cnt <= we_cnt + 1;
      end else begin
        ram_do_r <= mem[RAM_ADDR];
        raddr_log[rd_cnt & 1023] <= RAM_ADDR;
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  // Reference register map and counters
  logic [15:0] ref_mem [0:WORDS-1];
  int n_checks = 0;
  int n_fail = 0;

  // Per-transaction observations collected by run_txn
  logic [15:0] wr_src [$];
  logic [15:0] rd_got [$];
  bit          t_done;
  logic [7:0]  t_exc;
  int t_acc, t_first_rdv, t_done_cyc, t_last_rd, t_last_wr;
  int t_wi, t_stall_seen, t_stall_viol, t_overlap;

  function automatic logic [7:0] ref_exc(input int addr, input int qty);
    if (qty == 0 || qty > int'(MAX_QTY)) return 8'h03;
    if (addr + qty > int'(WORDS)) return 8'h02;
    return 8'h00;
  endfunction

  task automatic preload(input int a, input logic [15:0] d);
    @(negedge CLOCK);
    pl_en = 1'b1; pl_addr = 4'(a); pl_data = d;
    @(negedge CLOCK);
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Drives one request to completion (bounded), recording what it observed
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] qty,
                         input int stall0);
    int st;
    bit held, req_hs, wr_hs;
    logic [15:0] held_data;
    rd_got.delete();
    t_done = 0; t_exc = 8'hEE; t_acc = -1; t_first_rdv = -1; t_done_cyc = -1;
    t_last_rd = -1; t_last_wr = -1; t_wi = 0; t_stall_seen = 0; t_stall_viol = 0;
    t_overlap = 0;
    st = stall0; held = 0; held_data = '0;
    @(negedge CLOCK);
    REQ_VALID = 1'b1; REQ_WR = wr; REQ_ADDR = addr; REQ_QTY = qty;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (DONE) begin
        t_done = 1; t_exc = EXC; t_done_cyc = cyc;
        break;
      end
      req_hs = REQ_VALID && REQ_READY;
      if (req_hs) t_acc = cyc;
      if (RAM_EN && RD_VALID) t_overlap++;
      if (held && (!RD_VALID || RD_DATA !== held_data)) t_stall_viol++;
      held = 0;
      if (RD_VALID) begin
        if (t_first_rdv < 0) t_first_rdv = cyc;
        if (st > 0) begin
          RD_READY = 1'b0; st--; t_stall_seen++; held = 1; held_data = RD_DATA;
        end else begin
          RD_READY = 1'b1; rd_got.push_back(RD_DATA); t_last_rd = cyc;
        end
      end else begin
        RD_READY = 1'b1;
      end
      if (t_wi < int'(wr_src.size())) begin
        WR_VALID = 1'b1; WR_DATA = wr_src[t_wi];
      end else begin
        WR_VALID = 1'b0;
      end
      wr_hs = WR_VALID && WR_READY;
      if (wr_hs) t_last_wr = cyc;
      @(negedge CLOCK);
      if (req_hs) REQ_VALID = 1'b0;
      if (wr_hs) t_wi++;
    end
    REQ_VALID = 1'b0; WR_VALID = 1'b0; RD_READY = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    n_checks++;
    if (REQ_READY !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_ready: got %b expected 0", REQ_READY);
    end
    n_checks++;
    if ({WR_READY, RD_VALID, DONE, RAM_EN, RAM_WE} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 00000",
                         {WR_READY, RD_VALID, DONE, RAM_EN, RAM_WE});
    end
    n_checks++;
    if ({RD_DATA, EXC, RAM_ADDR, RAM_DI} !== 44'h0) begin
      n_fail++; $display("FAIL reset_values: got %h expected 0", {RD_DATA, EXC, RAM_ADDR, RAM_DI});
    end
    RESET = 1'b0;
    @(negedge CLOCK);
    n_checks++;
    if (REQ_READY !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b expected 1", REQ_READY);
    end
  endtask

  task automatic test_read_basic();
    int en0, rd0;
    logic [15:0] exp_w [3];
    exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333;
    for (int i = 0; i < 3; i++) preload(2 + i, exp_w[i]);
    wr_src.delete();
    en0 = en_cnt; rd0 = rd_cnt;
    run_txn(1'b0, 16'd2, 8'd3, 0);
    n_checks++;
    if (!t_done || t_exc !== 8'h00) begin
      n_fail++; $display("FAIL rd_basic_done: got done=%0d exc=%h expected done=1 exc=00", t_done, t_exc);
    end
    n_checks++;
    if (rd_got.size() != 3) begin
      n_fail++; $display("FAIL rd_basic_count: got %0d expected 3", rd_got.size());
    end
    for (int i = 0; i < 3 && i < int'(rd_got.size()); i++) begin
      n_checks++;
      if (rd_got[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL rd_basic_word%0d: got %h expected %h", i, rd_got[i], exp_w[i]);
      end
      n_checks++;
      if (raddr_log[(rd0 + i) & 1023] !== 4'(2 + i)) begin
        n_fail++; $display("FAIL rd_basic_addr%0d: got %0d expected %0d", i,
                           raddr_log[(rd0 + i) & 1023], 2 + i);
      end
    end
    n_checks++;
    if (en_cnt - en0 != 3) begin
      n_fail++; $display("FAIL rd_basic_en_count: got %0d expected 3", en_cnt - en0);
    end
    n_checks++;
    if (t_first_rdv - t_acc != 4) begin
      n_fail++; $display("FAIL rd_first_latency: got %0d expected 4", t_first_rdv - t_acc);
    end
    n_checks++;
    if (t_done_cyc - t_last_rd != 1) begin
      n_fail++; $display("FAIL rd_done_latency: got %0d expected 1", t_done_cyc - t_last_rd);
    end
  endtask

  task automatic test_write_basic();
    int we0;
    wr_src.delete();
    wr_src.push_back(16'hABCD); wr_src.push_back(16'h1234);
    we0 = we_cnt;
    run_txn(1'b1, 16'd14, 8'd2, 0);
    ref_mem[14] = 16'hABCD; ref_mem[15] = 16'h1234;
    n_checks++;
    if (!t_done || t_exc !== 8'h00) begin
      n_fail++; $display("FAIL wr_basic_done: got done=%0d exc=%h expected done=1 exc=00", t_done, t_exc);
    end
    n_checks++;
    if (mem[14] !== 16'hABCD || mem[15] !== 16'h1234) begin
      n_fail++; $display("FAIL wr_basic_data: got %h %h expected abcd 1234", mem[14], mem[15]);
    end
    n_checks++;
    if (we_cnt - we0 != 2 || t_wi != 2) begin
      n_fail++; $display("FAIL wr_basic_we_count: got we=%0d taken=%0d expected 2 2", we_cnt - we0, t_wi);
    end
    n_checks++;
    if (waddr_log[we0 & 1023] !== 4'd14 || waddr_log[(we0 + 1) & 1023] !== 4'd15) begin
      n_fail++; $display("FAIL wr_basic_addr: got %0d %0d expected 14 15",
                         waddr_log[we0 & 1023], waddr_log[(we0 + 1) & 1023]);
    end
    n_checks++;
    if (t_done_cyc - t_last_wr != WR_TAIL) begin
      n_fail++; $display("FAIL wr_done_latency: got %0d expected %0d", t_done_cyc - t_last_wr, WR_TAIL);
    end
  endtask

  task automatic test_exceptions();
    logic [15:0] ca [6];
    logic [7:0]  cq [6];
    logic [7:0]  ce [6];
    int en0;
    ca[0] = 16'd0;     cq[0] = 8'd0;   ce[0] = 8'h03;
    ca[1] = 16'd0;     cq[1] = 8'd9;   ce[1] = 8'h03;
    ca[2] = 16'd15;    cq[2] = 8'd2;   ce[2] = 8'h02;
    ca[3] = 16'hFFFF;  cq[3] = 8'd1;   ce[3] = 8'h02;
    ca[4] = 16'd9;     cq[4] = 8'd8;   ce[4] = 8'h02;
    ca[5] = 16'd20;    cq[5] = 8'd255; ce[5] = 8'h03;
    wr_src.delete(); wr_src.push_back(16'h5A5A);
    for (int i = 0; i < 6; i++) begin
      en0 = en_cnt;
      run_txn(1'($urandom_range(0, 1)), ca[i], cq[i], 0);
      n_checks++;
      if (!t_done || t_exc !== ce[i]) begin
        n_fail++; $display("FAIL exc_case%0d: got done=%0d exc=%h expected done=1 exc=%h",
                           i, t_done, t_exc, ce[i]);
      end
      n_checks++;
      if (en_cnt != en0 || t_wi != 0) begin
        n_fail++; $display("FAIL exc_no_ram%0d: got en=%0d taken=%0d expected 0 0", i, en_cnt - en0, t_wi);
      end
      n_checks++;
      if (t_done_cyc - t_acc != 2) begin
        n_fail++; $display("FAIL exc_latency%0d: got %0d expected 2", i, t_done_cyc - t_acc);
      end
    end
    repeat (3) @(negedge CLOCK);
    n_checks++;
    if (EXC !== 8'h03 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL exc_hold: got exc=%h done=%b expected 03 0", EXC, DONE);
    end
  endtask

  task automatic test_stall();
    int en0;
    logic [15:0] w0, w1;
    w0 = 16'($urandom); w1 = 16'($urandom);
    preload(6, w0); preload(7, w1);
    wr_src.delete();
    en0 = en_cnt;
    run_txn(1'b0, 16'd6, 8'd2, 5);
    n_checks++;
    if (!t_done || t_exc !== 8'h00 || rd_got.size() != 2) begin
      n_fail++; $display("FAIL stall_done: got done=%0d exc=%h n=%0d expected 1 00 2", t_done, t_exc, rd_got.size());
    end else begin
      n_checks++;
      if (rd_got[0] !== w0 || rd_got[1] !== w1) begin
        n_fail++; $display("FAIL stall_words: got %h %h expected %h %h", rd_got[0], rd_got[1], w0, w1);
      end
    end
    n_checks++;
    if (t_stall_seen != 5 || t_stall_viol != 0) begin
      n_fail++; $display("FAIL stall_hold: got seen=%0d viol=%0d expected 5 0", t_stall_seen, t_stall_viol);
    end
    n_checks++;
    if (t_overlap != 0 || en_cnt - en0 != 2) begin
      n_fail++; $display("FAIL stall_ram_en: got overlap=%0d en=%0d expected 0 2", t_overlap, en_cnt - en0);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    int q, st, pick, en0;
    logic wr;
    logic [7:0] e;
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 9);
      if (pick == 0)      a = 16'hFFFF;
      else if (pick == 1) a = 16'($urandom_range(16, 300));
      else                a = 16'($urandom_range(0, 15));
      q  = $urandom_range(0, 9);
      st = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      e  = ref_exc(int'(a), q);
      wr_src.delete();
      if (wr) for (int i = 0; i < q; i++) wr_src.push_back(16'($urandom));
      en0 = en_cnt;
      run_txn(wr, a, 8'(q), st);
      n_checks++;
      if (!t_done || t_exc !== e) begin
        n_fail++; $display("FAIL rand%0d_exc: got done=%0d exc=%h expected done=1 exc=%h", n, t_done, t_exc, e);
      end
      n_checks++;
      if (en_cnt - en0 != ((e == 8'h00) ? q : 0)) begin
        n_fail++; $display("FAIL rand%0d_en: got %0d expected %0d", n, en_cnt - en0, (e == 8'h00) ? q : 0);
      end
      if (e == 8'h00 && wr) begin
        for (int i = 0; i < q; i++) ref_mem[int'(a) + i] = wr_src[i];
        n_checks++;
        if (t_wi != q) begin
          n_fail++; $display("FAIL rand%0d_taken: got %0d expected %0d", n, t_wi, q);
        end
      end else if (e == 8'h00) begin
        n_checks++;
        if (rd_got.size() != q) begin
          n_fail++; $display("FAIL rand%0d_rdcount: got %0d expected %0d", n, rd_got.size(), q);
        end
        for (int i = 0; i < q && i < int'(rd_got.size()); i++) begin
          n_checks++;
          if (rd_got[i] !== ref_mem[int'(a) + i]) begin
            n_fail++; $display("FAIL rand%0d_word%0d: got %h expected %h", n, i, rd_got[i], ref_mem[int'(a) + i]);
          end
        end
      end
    end
    for (int i = 0; i < int'(WORDS); i++) begin
      n_checks++;
      if (mem[i] !== ref_mem[i]) begin
        n_fail++; $display("FAIL map_word%0d: got %h expected %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_reset_midwrite();
    logic [15:0] d [4];
    logic [15:0] old6, old7;
    int wi, en_mark;
    bit saw_done, hit, hs;
    for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
    old6 = 16'h6666; old7 = 16'h7777;
    preload(6, old6); preload(7, old7);
    saw_done = 0; hit = 0; wi = 0;
    @(negedge CLOCK);
    REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_ADDR = 16'd4; REQ_QTY = 8'd4;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (DONE) saw_done = 1;
      if (REQ_READY) begin end else REQ_VALID = 1'b0;
      if (wi == 2 && WR_READY) begin
        RESET = 1'b1; hit = 1;
        break;
      end
      WR_VALID = (wi < 4); WR_DATA = d[wi & 3];
      hs = WR_VALID && WR_READY;
      @(negedge CLOCK);
      if (hs) wi++;
    end
    REQ_VALID = 1'b0; WR_VALID = 1'b0;
    repeat (2) begin
      @(negedge CLOCK);
      if (DONE) saw_done = 1;
    end
    en_mark = en_cnt;
    RESET = 1'b0;
    @(negedge CLOCK);
    n_checks++;
    if (hit != 1 || REQ_READY !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ready: got hit=%0d ready=%b expected 1 1", hit, REQ_READY);
    end
    repeat (3) begin
      @(negedge CLOCK);
      if (DONE) saw_done = 1;
    end
    n_checks++;
    if (saw_done || en_cnt != en_mark) begin
      n_fail++; $display("FAIL rst_mid_quiet: got done=%0d en=%0d expected 0 0", saw_done, en_cnt - en_mark);
    end
    ref_mem[4] = d[0]; ref_mem[5] = d[1];
    n_checks++;
    if (mem[4] !== d[0] || mem[5] !== d[1] || mem[6] !== old6 || mem[7] !== old7) begin
      n_fail++; $display("FAIL rst_mid_map: got %h %h %h %h expected %h %h %h %h",
                         mem[4], mem[5], mem[6], mem[7], d[0], d[1], old6, old7);
    end
  endtask

`ifdef REG_READBACK_EN
  task automatic test_readback();
    logic [15:0] old5;
    old5 = 16'h5555;
    preload(5, old5);
    wr_src.delete();
    for (int i = 0; i < 3; i++) wr_src.push_back(16'($urandom));
    corrupt_at = we_cnt + 1;
    run_txn(1'b1, 16'd3, 8'd3, 0);
    corrupt_at = -1;
    ref_mem[3] = wr_src[0]; ref_mem[4] = wr_src[1];
    n_checks++;
    if (!t_done || t_exc !== 8'h04) begin
      n_fail++; $display("FAIL rb_exc: got done=%0d exc=%h expected 1 04", t_done, t_exc);
    end
    n_checks++;
    if (t_wi != 2 || t_done_cyc - t_last_wr != 3) begin
      n_fail++; $display("FAIL rb_abort: got taken=%0d lat=%0d expected 2 3", t_wi, t_done_cyc - t_last_wr);
    end
    n_checks++;
    if (mem[3] !== wr_src[0] || mem[4] !== wr_src[1] || mem[5] !== old5) begin
      n_fail++; $display("FAIL rb_map: got %h %h %h expected %h %h %h",
                         mem[3], mem[4], mem[5], wr_src[0], wr_src[1], old5);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    for (int i = 0; i < int'(WORDS); i++) preload(i, 16'($urandom));
    test_read_basic();
    test_write_basic();
    test_exceptions();
    test_stall();
`ifdef REG_READBACK_EN
    test_readback();
`endif
    test_random();
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
